axi_wr_dispatch: RTL

- AXI4 write-slave front end that accepts multi-beat bursts and steers each data beat into one of NUM_CH input FIFOs.
- Each pushed beat carries data, strobes, a shared record index and a per-burst mode flag.
- Sits between the fabric AXI master and the per-channel decoder input FIFOs.
- Generalises the single-beat, two-FIFO write FSM: adds burst length, WLAST checking, SLVERR on bad decode, and parametrised width and channel count.

---
 rtl/axi_wr_dispatch_pkg.sv | 17 +
 rtl/axi_wr_dispatch_beat_counter.sv | 25 ++
 rtl/axi_wr_dispatch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/axi_wr_dispatch_pkg.sv
// axi_wr_dispatch_pkg: shared FSM states, response codes and address bit positions
package axi_wr_dispatch_pkg;
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DATA,
        ST_DRAIN,
        ST_RESP
    } state_t;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam int ADDR_LAST = 0;
    localparam int ADDR_MODE = 1;
    localparam int ADDR_ERR  = 7;
endpackage

// File: rtl/axi_wr_dispatch_beat_counter.sv
// wr_beat_counter: remaining-beat counter for one write burst
module wr_beat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] len,
    input  logic       dec,
    output logic       last_beat,
    output logic       zero
);
    logic [8:0] count;

    // load awlen+1 at address acceptance, count down on every accepted beat
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= {1'b0, len} + 9'd1;
        else if (dec && !zero)
            count <= count - 9'd1;
    end

    assign last_beat = count == 9'd1;
    assign zero      = count == 9'd0;
endmodule

// File: rtl/axi_wr_dispatch.sv
// axi_wr_dispatch: AXI4 write slave steering burst beats into per-channel FIFOs
module axi_wr_dispatch
    import axi_wr_dispatch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 10,
    parameter int CH_LSB = 4,
    localparam int STRB_W = DATA_W / 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [31:0]       s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [NUM_CH-1:0] fifo_full,
    output logic [NUM_CH-1:0] fifo_clr,
    output logic [NUM_CH-1:0] fifo_push,
    output logic [DATA_W-1:0] push_data,
    output logic [STRB_W-1:0] push_strb,
    output logic [IDX_W-1:0]  push_index,
    output logic              push_mode
);
    state_t            state;
    logic [ID_W-1:0]   id;
    logic              last;
    logic              mode;
    logic              err;
    logic [CH_W-1:0]   ch;
    logic [IDX_W-1:0]  index;
    logic              last_beat;
    logic              zero;
    logic              beat;
    logic              unused_addr;

    // only a few address bits carry meaning; the rest are don't-care
    assign unused_addr = ^s_awaddr;

    wr_beat_counter u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (state == ST_IDLE && s_awvalid),
        .len       (s_awlen),
        .dec       (beat),
        .last_beat (last_beat),
        .zero      (zero)
    );

    assign s_awready  = state == ST_IDLE;
    assign s_wready   = state == ST_DATA ? !fifo_full[ch] && !zero : state == ST_DRAIN;
    assign beat       = state == ST_DATA && s_wvalid && s_wready;
    assign s_bvalid   = state == ST_RESP;
    assign s_bid      = s_bvalid ? id : '0;
    assign s_bresp    = s_bvalid && err ? BRESP_SLVERR : BRESP_OKAY;
    assign fifo_clr   = state == ST_INIT ? {NUM_CH{1'b1}} : '0;
    assign fifo_push  = beat ? NUM_CH'(1) << ch : '0;
    assign push_data  = beat ? s_wdata : '0;
    assign push_strb  = beat ? s_wstrb : '0;
    assign push_index = beat ? index : '0;
    assign push_mode  = beat && mode;

    // write FSM: capture the burst, steer or drain beats, respond, advance the record index
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            id    <= '0;
            last  <= 1'b0;
            mode  <= 1'b0;
            err   <= 1'b0;
            ch    <= '0;
            index <= '0;
        end else begin
            case (state)
                ST_INIT: state <= ST_IDLE;
                ST_IDLE: begin
                    if (s_awvalid) begin
                        id    <= s_awid;
                        last  <= s_awaddr[ADDR_LAST];
                        mode  <= s_awaddr[ADDR_MODE];
                        ch    <= s_awaddr[CH_LSB +: CH_W];
                        err   <= s_awaddr[ADDR_ERR];
                        state <= s_awaddr[ADDR_ERR] ? ST_DRAIN : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat && s_wlast) begin
                        err   <= !last_beat;
                        state <= ST_RESP;
                    end else if (beat && last_beat) begin
                        err   <= 1'b1;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (s_wvalid && s_wlast)
                        state <= ST_RESP;
                end
                ST_RESP: begin
                    if (s_bready) begin
                        if (last && !err)
                            index <= index + 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule
